// File: rtl/skip_fetch_unit_pkg.sv
// Shared types and constants for the skip-fetch stage: table entry layouts,
// reset defaults, the bus block index of the skip table and field offsets.
package VSTypes;

    localparam int SKIP_ADDR_W  = 32;
    localparam int SKIP_COUNT_W = 8;

    localparam logic [31:0] SkipTableBlockIdx = 32'h0000_0100;

    localparam logic [1:0] SKIP_OFS_MATCH  = 2'd0;
    localparam logic [1:0] SKIP_OFS_CTRL   = 2'd1;
    localparam logic [1:0] SKIP_OFS_TARGET = 2'd2;
    localparam logic [1:0] SKIP_OFS_LIMIT  = 2'd3;

    typedef struct packed {
        logic [SKIP_ADDR_W-1:0]  match_pc;
        logic                    valid;
        logic [SKIP_ADDR_W-1:0]  target_pc;
        logic [SKIP_COUNT_W-1:0] limit;
    } SkipTableEntryType;

    typedef struct packed {
        logic [SKIP_COUNT_W-1:0] count;
    } SkipStatusTableEntryType;

    localparam SkipTableEntryType       SkipTableEntryDefault = '0;
    localparam SkipStatusTableEntryType SkipStatusDefault     = '0;

endpackage

// File: rtl/skip_fetch_unit_if.sv
// Lookup and table-programming signals of the skip-fetch stage; master drives
// predicted PCs and writes, slave returns the registered next-PC result.
interface skip_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PredictedPCIn;
    logic                  PCValidIn;
    logic                  StallIn;
    logic [ADDR_WIDTH-1:0] NextPCOut;
    logic                  NextPCValidOut;
    logic                  HitOut;
    logic                  SkipTakenOut;
    logic                  WriteEnIn;
    logic [ADDR_WIDTH-1:0] WriteAddressIn;
    logic [ADDR_WIDTH-1:0] WriteDataIn;

    modport master (
        output PredictedPCIn, PCValidIn, StallIn,
        output WriteEnIn, WriteAddressIn, WriteDataIn,
        input  NextPCOut, NextPCValidOut, HitOut, SkipTakenOut
    );

    modport slave (
        input  PredictedPCIn, PCValidIn, StallIn,
        input  WriteEnIn, WriteAddressIn, WriteDataIn,
        output NextPCOut, NextPCValidOut, HitOut, SkipTakenOut
    );
endinterface

// File: rtl/skip_fetch_unit_cam.sv
// Combinational CAM compare of one PC against all table entries, with the
// lowest matching index winning.
module skip_cam_match #(
    parameter int N     = 8,
    parameter int W     = 32,
    parameter int IDX_W = $clog2(N)
)(
    input  logic [N-1:0][W-1:0] match_pc,
    input  logic [N-1:0]        valid,
    input  logic [W-1:0]        pc,
    output logic                hit,
    output logic [IDX_W-1:0]    idx
);
    logic [N-1:0] hit_vec_s;

    // Match vector and priority encode; scanning downwards leaves the lowest hit.
    always_comb begin
        hit_vec_s = '0;
        idx       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            hit_vec_s[i] = valid[i] && (match_pc[i] == pc);
            idx          = hit_vec_s[i] ? i[IDX_W-1:0] : idx;
        end
        hit = |hit_vec_s;
    end
endmodule

// File: rtl/skip_fetch_unit.sv
// Skip-fetch stage: memory-mapped skip table, per-entry iteration counters and
// the registered next-fetch-PC output.
module skip_fetch_unit
    import VSTypes::*;
#(
    parameter int                    SKIP_TABLE_SIZE = 8,
    parameter int                    ADDR_WIDTH      = SKIP_ADDR_W,
    parameter int                    COUNT_WIDTH     = SKIP_COUNT_W,
    parameter logic [ADDR_WIDTH-1:0] TABLE_BLOCK_IDX = SkipTableBlockIdx
)(
    input logic              ClockIn,
    input logic              AsyncResetIn,
    skip_fetch_unit_if.slave bus
);
    localparam int IDX_W = $clog2(SKIP_TABLE_SIZE);
    localparam int BLK_W = ADDR_WIDTH - IDX_W - 2;

    SkipTableEntryType       table_r  [SKIP_TABLE_SIZE];
    SkipStatusTableEntryType status_r [SKIP_TABLE_SIZE];

    logic [SKIP_TABLE_SIZE-1:0][ADDR_WIDTH-1:0] match_pc_s;
    logic [SKIP_TABLE_SIZE-1:0]                 valid_s;
    logic                    hit_s;
    logic [IDX_W-1:0]        hit_idx_s;
    logic                    skip_s;
    logic [ADDR_WIDTH-1:0]   next_pc_s;
    logic                    lookup_s;
    logic                    wr_hit_s;
    logic                    wr_clr_s;
    logic [IDX_W-1:0]        wr_idx_s;
    logic [1:0]              wr_ofs_s;

    logic [ADDR_WIDTH-1:0]   next_pc_r;
    logic                    next_valid_r;
    logic                    hit_r;
    logic                    skip_r;

    // Flatten the table into the CAM compare inputs.
    always_comb begin
        match_pc_s = '0;
        valid_s    = '0;
        for (int i = 0; i < SKIP_TABLE_SIZE; i++) begin
            match_pc_s[i] = table_r[i].match_pc;
            valid_s[i]    = table_r[i].valid;
        end
    end

    skip_cam_match #(
        .N     (SKIP_TABLE_SIZE),
        .W     (ADDR_WIDTH),
        .IDX_W (IDX_W)
    ) u_cam (
        .match_pc (match_pc_s),
        .valid    (valid_s),
        .pc       (bus.PredictedPCIn),
        .hit      (hit_s),
        .idx      (hit_idx_s)
    );

    assign lookup_s = bus.PCValidIn && !bus.StallIn;
    assign wr_hit_s = bus.WriteEnIn &&
                      (bus.WriteAddressIn[ADDR_WIDTH-1:IDX_W+2] == TABLE_BLOCK_IDX[BLK_W-1:0]);
    assign wr_idx_s = bus.WriteAddressIn[IDX_W+1:2];
    assign wr_ofs_s = bus.WriteAddressIn[1:0];
    assign wr_clr_s = wr_hit_s && ((wr_ofs_s == SKIP_OFS_CTRL) || (wr_ofs_s == SKIP_OFS_LIMIT));

    // Redirect decision from the pre-write table state.
    always_comb begin
        if (hit_s && (status_r[hit_idx_s].count < table_r[hit_idx_s].limit)) begin
            skip_s    = 1'b1;
            next_pc_s = table_r[hit_idx_s].target_pc;
        end else begin
            skip_s    = 1'b0;
            next_pc_s = bus.PredictedPCIn;
        end
    end

    // Table field writes from the word-write bus.
    always_ff @(posedge ClockIn or posedge AsyncResetIn) begin
        if (AsyncResetIn) begin
            for (int i = 0; i < SKIP_TABLE_SIZE; i++) table_r[i] <= SkipTableEntryDefault;
        end else if (wr_hit_s) begin
            case (wr_ofs_s)
                SKIP_OFS_MATCH:  table_r[wr_idx_s].match_pc  <= bus.WriteDataIn;
                SKIP_OFS_CTRL:   table_r[wr_idx_s].valid     <= bus.WriteDataIn[ADDR_WIDTH-1];
                SKIP_OFS_TARGET: table_r[wr_idx_s].target_pc <= bus.WriteDataIn;
                SKIP_OFS_LIMIT:  table_r[wr_idx_s].limit     <= bus.WriteDataIn[COUNT_WIDTH-1:0];
                default:         table_r[wr_idx_s]           <= table_r[wr_idx_s];
            endcase
        end
    end

    // Iteration counters; a control/limit write clear outranks the lookup update.
    always_ff @(posedge ClockIn or posedge AsyncResetIn) begin
        if (AsyncResetIn) begin
            for (int i = 0; i < SKIP_TABLE_SIZE; i++) status_r[i] <= SkipStatusDefault;
        end else begin
            for (int i = 0; i < SKIP_TABLE_SIZE; i++) begin
                if (wr_clr_s && (wr_idx_s == IDX_W'(i))) begin
                    status_r[i].count <= '0;
                end else if (lookup_s && hit_s && (hit_idx_s == IDX_W'(i))) begin
                    status_r[i].count <= skip_s ? (status_r[i].count + COUNT_WIDTH'(1)) : '0;
                end
            end
        end
    end

    // Output register; stall freezes everything, an idle cycle keeps the PC.
    always_ff @(posedge ClockIn or posedge AsyncResetIn) begin
        if (AsyncResetIn) begin
            next_pc_r    <= '0;
            next_valid_r <= 1'b0;
            hit_r        <= 1'b0;
            skip_r       <= 1'b0;
        end else if (!bus.StallIn) begin
            if (bus.PCValidIn) begin
                next_pc_r    <= next_pc_s;
                next_valid_r <= 1'b1;
                hit_r        <= hit_s;
                skip_r       <= skip_s;
            end else begin
                next_valid_r <= 1'b0;
                hit_r        <= 1'b0;
                skip_r       <= 1'b0;
            end
        end
    end

    assign bus.NextPCOut      = next_pc_r;
    assign bus.NextPCValidOut = next_valid_r;
    assign bus.HitOut         = hit_r;
    assign bus.SkipTakenOut   = skip_r;
endmodule
